// File: rtl/wb_port_arbiter_pkg.sv
// Shared types for the write-back port arbiter: request struct, grant source,
// and the one-hot helper used to build the pending-register mask.
package wb_port_arbiter_pkg;

  localparam int REG_W  = 5;
  localparam int DATA_W = 32;

  typedef struct packed {
    logic              we;
    logic [REG_W-1:0]  wreg;
    logic [DATA_W-1:0] data;
  } wb_req_t;

  typedef enum logic [1:0] {
    GNT_NONE,
    GNT_PIPE,
    GNT_AUX
  } gnt_src_e;

  function automatic logic [31:0] reg_onehot(input logic [REG_W-1:0] r);
    return 32'(1) << r;
  endfunction

endpackage

// File: rtl/wb_aux_fifo.sv
// DEPTH-entry synchronous FIFO for auxiliary write-back requests; exposes
// per-entry valid and destination so the top can form the pending mask.
module wb_aux_fifo
  import wb_port_arbiter_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        push_i,
  input  logic [REG_W-1:0]            push_reg_i,
  input  logic [DATA_W-1:0]           push_data_i,
  input  logic                        pop_i,
  output logic                        full_o,
  output logic                        empty_o,
  output wb_req_t                     head_o,
  output logic [DEPTH-1:0]            entry_valid_o,
  output logic [DEPTH-1:0][REG_W-1:0] entry_reg_o
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]    count_q, count_d;
  logic [DEPTH-1:0]  valid_q, valid_d;
  logic [REG_W-1:0]  reg_q  [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];
  logic              push_ok, pop_ok;

  assign full_o  = (count_q == (PTR_W+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign push_ok = push_i & ~full_o;
  assign pop_ok  = pop_i & ~empty_o;

  // NOTE: every signal driven in always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    valid_d  = valid_q;
    if (push_ok) begin
      wr_ptr_d          = wr_ptr_q + PTR_W'(1);
      valid_d[wr_ptr_q] = 1'b1;
    end
    if (pop_ok) begin
      rd_ptr_d          = rd_ptr_q + PTR_W'(1);
      valid_d[rd_ptr_q] = 1'b0;
    end
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + (PTR_W+1)'(1);
      2'b01:   count_d = count_q - (PTR_W+1)'(1);
      default: count_d = count_q;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together on the edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      valid_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      valid_q  <= valid_d;
    end
  end

  // NOTE: the storage array has no reset; valid_q qualifies every use of its contents.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      reg_q[wr_ptr_q]  <= push_reg_i;
      data_q[wr_ptr_q] <= push_data_i;
    end
  end

  assign head_o = '{we: ~empty_o, wreg: reg_q[rd_ptr_q], data: data_q[rd_ptr_q]};

  always_comb begin
    entry_valid_o = valid_q;
    for (int i = 0; i < DEPTH; i++) entry_reg_o[i] = reg_q[i];
  end

endmodule

// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter: pipeline has priority, auxiliary writes queue
// and drain in idle slots or a forced slot. Optional stats under WB_ARB_STATS_EN.
module wb_port_arbiter
  import wb_port_arbiter_pkg::*;
#(
  parameter int DEPTH    = 4,
  parameter int MAX_WAIT = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              pipe_regwrite,
  input  logic [REG_W-1:0]  pipe_wrreg,
  input  logic [DATA_W-1:0] pipe_wrdata,
  output logic              pipe_stall,
  input  logic              aux_valid,
  output logic              aux_ready,
  input  logic [REG_W-1:0]  aux_wrreg,
  input  logic [DATA_W-1:0] aux_wrdata,
  output logic              rf_we,
  output logic [REG_W-1:0]  rf_wrreg,
  output logic [DATA_W-1:0] rf_wrdata,
  output logic [31:0]       aux_pending_mask
`ifdef WB_ARB_STATS_EN
  ,
  output logic [31:0]       stat_forced,
  output logic [31:0]       stat_full_cycles
`endif
);

  localparam int CNT_W = $clog2(MAX_WAIT + 1);

  logic                        fifo_full, fifo_empty, fifo_push, fifo_pop;
  wb_req_t                     fifo_head;
  logic [DEPTH-1:0]            entry_valid;
  logic [DEPTH-1:0][REG_W-1:0] entry_reg;
  gnt_src_e                    gnt;
  logic [CNT_W-1:0]            wait_cnt_q, wait_cnt_d;
  logic                        force_q, force_d;

  // Writes to r0 complete the handshake but are never queued.
  assign aux_ready = ~fifo_full;
  assign fifo_push = aux_valid & aux_ready & (aux_wrreg != '0);
  assign fifo_pop  = (gnt == GNT_AUX);

  wb_aux_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk          (clk),
    .reset        (reset),
    .push_i       (fifo_push),
    .push_reg_i   (aux_wrreg),
    .push_data_i  (aux_wrdata),
    .pop_i        (fifo_pop),
    .full_o       (fifo_full),
    .empty_o      (fifo_empty),
    .head_o       (fifo_head),
    .entry_valid_o(entry_valid),
    .entry_reg_o  (entry_reg)
  );

  always_comb begin
    gnt = GNT_NONE;
    if (force_q && !fifo_empty) gnt = GNT_AUX;
    else if (pipe_regwrite)     gnt = GNT_PIPE;
    else if (!fifo_empty)       gnt = GNT_AUX;
  end

  always_comb begin
    rf_we     = 1'b0;
    rf_wrreg  = '0;
    rf_wrdata = '0;
    case (gnt)
      GNT_PIPE: begin
        rf_we     = 1'b1;
        rf_wrreg  = pipe_wrreg;
        rf_wrdata = pipe_wrdata;
      end
      GNT_AUX: begin
        rf_we     = 1'b1;
        rf_wrreg  = fifo_head.wreg;
        rf_wrdata = fifo_head.data;
      end
      default: ;
    endcase
  end

  assign pipe_stall = pipe_regwrite & (gnt != GNT_PIPE);

  // Starvation: count pipeline wins over a waiting head, force one slot at MAX_WAIT.
  always_comb begin
    wait_cnt_d = '0;
    force_d    = 1'b0;
    if (gnt == GNT_PIPE && !fifo_empty) begin
      wait_cnt_d = wait_cnt_q + CNT_W'(1);
      force_d    = (wait_cnt_q == CNT_W'(MAX_WAIT - 1));
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wait_cnt_q <= '0;
      force_q    <= 1'b0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
      force_q    <= force_d;
    end
  end

  always_comb begin
    aux_pending_mask = '0;
    for (int i = 0; i < DEPTH; i++)
      if (entry_valid[i]) aux_pending_mask |= reg_onehot(entry_reg[i]);
  end

`ifdef WB_ARB_STATS_EN
  logic [31:0] stat_forced_q, stat_full_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stat_forced_q <= '0;
      stat_full_q   <= '0;
    end else begin
      if (force_q && !fifo_empty && stat_forced_q != '1) stat_forced_q <= stat_forced_q + 32'd1;
      if (aux_valid && !aux_ready && stat_full_q != '1) stat_full_q <= stat_full_q + 32'd1;
    end
  end

  assign stat_forced      = stat_forced_q;
  assign stat_full_cycles = stat_full_q;
`endif

endmodule

// File: doc/wb_port_arbiter.md
Name: wb_port_arbiter

Overview:
- Shares the single register-file write port between the pipeline write-back stage and an auxiliary long-latency requester (multiply/divide unit or delayed load return).
- The pipeline has priority. Auxiliary writes are buffered in a small FIFO and drained in idle write-back cycles.
- A starvation counter forces a one-cycle pipeline stall so the FIFO head can drain.
- Publishes a pending-register mask that decode uses for RAW interlock.

Parameters:
- DEPTH, 4, auxiliary FIFO entries (power of two, at least 2).
- MAX_WAIT, 8, consecutive denied cycles with a non-empty FIFO before a forced slot (at least 1).

Ports:
- clk  in  1  clock.
- reset  in  1  reset, asynchronous, active-high.
- pipe_regwrite  in  1  write-back stage requests a register write.
- pipe_wrreg  in  5  write-back destination register.
- pipe_wrdata  in  32  write-back data.
- pipe_stall  out  1  write-back request is not granted this cycle; the pipeline holds the WB stage and upstream stages.
- aux_valid  in  1  auxiliary write offered.
- aux_ready  out  1  FIFO can accept an entry.
- aux_wrreg  in  5  auxiliary destination register.
- aux_wrdata  in  32  auxiliary data.
- rf_we  out  1  register-file write enable.
- rf_wrreg  out  5  register-file write address.
- rf_wrdata  out  32  register-file write data.
- aux_pending_mask  out  32  bit n set if any queued entry targets register n.

Behaviour:
- Reset: FIFO empty, starvation count 0, force flag 0. Outputs: aux_ready=1, rf_we=0, pipe_stall=0, aux_pending_mask=0. Reset mid-operation discards all queued writes.
- Accept: an entry is pushed on aux_valid & aux_ready. aux_ready = !full, registered from occupancy, with no same-cycle pop bypass.
- aux_wrreg=0: handshake completes, but nothing is queued and no mask bit is set.
- Latency: a pushed entry can reach the register file no earlier than the next cycle.
- Grant, evaluated combinationally each cycle in this order:
  - force=1 and FIFO non-empty: grant the FIFO head. pipe_stall = pipe_regwrite. Pop the head.
  - else pipe_regwrite=1: grant the pipeline. pipe_stall=0.
  - else FIFO non-empty: grant the FIFO head and pop it.
  - else rf_we=0.
- rf_wrreg and rf_wrdata come from the granted source. They are 0 when rf_we=0.
- Pipeline writes to r0 pass through unchanged; the register file ignores them.
- Starvation counter, updated on each clock edge:
  - FIFO non-empty and pipeline granted: count += 1.
  - Any FIFO grant or FIFO empty: count clears to 0.
  - force <= (count == MAX_WAIT-1) & pipeline granted & FIFO non-empty. Force lasts exactly one cycle.
- Simultaneous push and pop: both happen. Occupancy is unchanged and the pointers wrap modulo DEPTH.
- Full FIFO: aux_ready=0 until a pop. The held aux_valid request is accepted on the cycle after the pop.
- Mask:
  - Per-entry valid AND one-hot(reg), OR-reduced over the FIFO.
  - Reflects registered state only; a same-cycle push does not appear until the next cycle.
  - A popped entry's bit clears in the cycle after its write. Duplicate destinations keep the bit set until the last one drains.
- Ordering: FIFO entries drain in order. Decode stalls any instruction whose destination or source hits the mask, so the pipeline and auxiliary writes never race on the same register.

Optional Feature:
- Macro WB_ARB_STATS_EN.
- When defined, adds two 32-bit outputs:
  - stat_forced: count of forced slots.
  - stat_full_cycles: count of cycles with aux_valid & !aux_ready.
- Both counters are reset to 0 by reset and saturate at all-ones.
- When undefined, these ports and counters are absent, and all other behaviour is identical.

Decomposition:
- Shared package holds:
  - REG_W=5, DATA_W=32 constants.
  - The wb_req struct typedef {we, reg, data}.
  - The grant-source enum {GNT_NONE, GNT_PIPE, GNT_AUX}.
- One natural sub-module: wb_aux_fifo, a DEPTH-entry synchronous FIFO with full/empty flags and per-entry valid/reg exposed for mask generation.
- Arbitration and the starvation counter stay in the top level.

Test Plan:
- Reset during operation: push 2 aux entries, assert reset -> rf_we=0, aux_pending_mask=0, aux_ready=1. No queued write ever appears afterwards.
- Idle drain: pipe_regwrite=0, push aux {r5, 0xDEADBEEF} at cycle 0 -> cycle 1 rf_we=1, rf_wrreg=5, rf_wrdata=0xDEADBEEF. Mask bit 5 is set during cycle 1 and clear in cycle 2.
- Pipeline priority: pipe_regwrite=1 {r3, 0x11}, one aux entry {r4, 0x22} queued -> r3 is written first and r4 is written in the first cycle pipe_regwrite=0. pipe_stall stays 0 throughout.
- Starvation, MAX_WAIT=8: pipe_regwrite held at 1 with one queued aux entry {r7, 0x77} -> after 8 pipeline grants, the 9th cycle has pipe_stall=1 and writes r7=0x77. The next cycle grants the pipeline with the same held data.
- Full/wrap, DEPTH=4: push 4 entries with pipeline busy -> aux_ready=0. Push 6 more as the FIFO drains -> all 10 written in order with no loss or duplication.
- aux_wrreg=0 push -> handshake completes, no rf_we, mask unchanged. With WB_ARB_STATS_EN, stat_full_cycles counts every cycle of aux_valid & !aux_ready.
